// File: rtl/fetch_decode_unit.sv
// Fetch/decode controller for the 8-bit core: drives the ROM address from the PC,
// latches the instruction register and issues one-cycle EXEC strobes back to the PC, regfile, ALU and port.
module fetch_decode_unit #(
   parameter int bits = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [bits-1:0] pc_count,
   input  logic [7:0]      instr_data,
   input  logic            zero_flag,
   output logic [bits-1:0] rom_addr,
   output logic [7:0]      ir,
   output logic [1:0]      reg_sel,
   output logic [2:0]      imm_out,
   output logic [1:0]      alu_op,
   output logic            reg_we,
   output logic            out_we,
   output logic            pc_en,
   output logic [2:0]      pc_imm,
   output logic            halted
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;
   localparam logic [1:0] S_HALT  = 2'd3;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_JMP = 3'b100;
   localparam logic [2:0] OP_JZ  = 3'b101;
   localparam logic [2:0] OP_OUT = 3'b110;
   localparam logic [2:0] OP_HLT = 3'b111;

   logic [1:0] state_q, state_d;
   logic [7:0] ir_q, ir_d;
   logic       halted_q, halted_d;
   logic [2:0] opcode;

   assign opcode = ir_q[7:5];

   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      halted_d = halted_q;
      case (state_q)
         S_FETCH: state_d = S_LOAD;
         S_LOAD: begin
            state_d = S_EXEC;
            ir_d    = instr_data;
         end
         S_EXEC: begin
            if (opcode == OP_HLT) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_FETCH;
         ir_q     <= 8'h00;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         halted_q <= halted_d;
      end
   end

   // Strobes decode only registered state and ir; zero_flag matters solely in EXEC.
   always_comb begin
      alu_op = 2'b11;
      reg_we = 1'b0;
      out_we = 1'b0;
      pc_en  = 1'b0;
      pc_imm = 3'd0;
      if (state_q == S_EXEC) begin
         case (opcode)
            OP_NOP: begin
               pc_en  = 1'b1;
               pc_imm = 3'd1;
            end
            OP_LDI: begin
               reg_we = 1'b1;
               alu_op = 2'b00;
               pc_en  = 1'b1;
               pc_imm = 3'd1;
            end
            OP_ADD: begin
               reg_we = 1'b1;
               alu_op = 2'b01;
               pc_en  = 1'b1;
               pc_imm = 3'd1;
            end
            OP_SUB: begin
               reg_we = 1'b1;
               alu_op = 2'b10;
               pc_en  = 1'b1;
               pc_imm = 3'd1;
            end
            OP_JMP: begin
               pc_en  = 1'b1;
               pc_imm = ir_q[2:0];
            end
            OP_JZ: begin
               pc_en  = 1'b1;
               pc_imm = zero_flag ? ir_q[2:0] : 3'd1;
            end
            OP_OUT: begin
               out_we = 1'b1;
               pc_en  = 1'b1;
               pc_imm = 3'd1;
            end
            default: begin
               pc_en  = 1'b0;
               pc_imm = 3'd0;
            end
         endcase
      end
   end

   assign rom_addr = pc_count;
   assign ir       = ir_q;
   assign reg_sel  = ir_q[4:3];
   assign imm_out  = ir_q[2:0];
   assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit with a behavioural PC and synchronous ROM around it.
module tb_fetch_decode_unit;

   logic       clk;
   logic       reset;
   logic [7:0] pc_count;
   logic [7:0] instr_data;
   logic       zero_flag;
   logic [7:0] rom_addr;
   logic [7:0] ir;
   logic [1:0] reg_sel;
   logic [2:0] imm_out;
   logic [1:0] alu_op;
   logic       reg_we;
   logic       out_we;
   logic       pc_en;
   logic [2:0] pc_imm;
   logic       halted;

   logic [7:0] rom [0:255];
   int checks;
   int failures;

   fetch_decode_unit #(.bits(8)) dut (
      .clk(clk), .reset(reset), .pc_count(pc_count), .instr_data(instr_data),
      .zero_flag(zero_flag), .rom_addr(rom_addr), .ir(ir), .reg_sel(reg_sel),
      .imm_out(imm_out), .alu_op(alu_op), .reg_we(reg_we), .out_we(out_we),
      .pc_en(pc_en), .pc_imm(pc_imm), .halted(halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // progran_counter stand-in: reset wins over en
   always @(posedge clk) begin
      if (reset) pc_count <= 8'd0;
      else if (pc_en) pc_count <= pc_count + {5'd0, pc_imm};
   end

   always @(posedge clk) instr_data <= rom[rom_addr];

   task automatic step();
      @(negedge clk);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
   endtask

   // Leaves the bench at a negedge with the DUT in FETCH, reset low.
   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      clear_rom();
      reset = 1'b1;
      step();
      step();
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL rst_ir got %0h want 0", ir); end
      checks++; if (reg_sel !== 2'd0) begin failures++; $display("FAIL rst_reg_sel got %0d want 0", reg_sel); end
      checks++; if (imm_out !== 3'd0) begin failures++; $display("FAIL rst_imm got %0d want 0", imm_out); end
      checks++; if (alu_op !== 2'b11) begin failures++; $display("FAIL rst_alu_op got %0d want 3", alu_op); end
      checks++; if ({reg_we, out_we, pc_en} !== 3'b000) begin failures++; $display("FAIL rst_strobes got %b want 000", {reg_we, out_we, pc_en}); end
      checks++; if (pc_imm !== 3'd0) begin failures++; $display("FAIL rst_pc_imm got %0d want 0", pc_imm); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got %b want 0", halted); end
      reset = 1'b0;
      checks++; if (rom_addr !== 8'd0) begin failures++; $display("FAIL rst_rom_addr got %0d want 0", rom_addr); end
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rst_pc_en_fetch got %b want 0", pc_en); end
      step();
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rst_pc_en_load got %b want 0", pc_en); end
      step();
      checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL rst_first_pc_en got %b want 1", pc_en); end
   endtask

   task automatic test_sequential();
      clear_rom();
      rom[0] = 8'h2D;
      rom[1] = 8'h4A;
      rom[2] = 8'h83;
      rom[5] = 8'h80;
      do_reset();
      step();
      step();
      checks++; if (reg_we !== 1'b1) begin failures++; $display("FAIL ldi_reg_we got %b want 1", reg_we); end
      checks++; if (reg_sel !== 2'd1) begin failures++; $display("FAIL ldi_reg_sel got %0d want 1", reg_sel); end
      checks++; if (imm_out !== 3'd5) begin failures++; $display("FAIL ldi_imm got %0d want 5", imm_out); end
      checks++; if (alu_op !== 2'b00) begin failures++; $display("FAIL ldi_alu_op got %0d want 0", alu_op); end
      checks++; if (pc_imm !== 3'd1) begin failures++; $display("FAIL ldi_pc_imm got %0d want 1", pc_imm); end
      checks++; if (out_we !== 1'b0) begin failures++; $display("FAIL ldi_out_we got %b want 0", out_we); end
      step();
      checks++; if (pc_count !== 8'd1) begin failures++; $display("FAIL seq_count1 got %0d want 1", pc_count); end
      checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL fetch_reg_we got %b want 0", reg_we); end
      checks++; if (alu_op !== 2'b11) begin failures++; $display("FAIL fetch_alu_op got %0d want 3", alu_op); end
      step();
      step();
      checks++; if (alu_op !== 2'b01) begin failures++; $display("FAIL add_alu_op got %0d want 1", alu_op); end
      checks++; if (imm_out !== 3'd2) begin failures++; $display("FAIL add_imm got %0d want 2", imm_out); end
      checks++; if (reg_we !== 1'b1) begin failures++; $display("FAIL add_reg_we got %b want 1", reg_we); end
      step();
      checks++; if (pc_count !== 8'd2) begin failures++; $display("FAIL seq_count2 got %0d want 2", pc_count); end
      // JMP +3 at address 2
      step();
      step();
      checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL jmp_pc_en got %b want 1", pc_en); end
      checks++; if (pc_imm !== 3'd3) begin failures++; $display("FAIL jmp_pc_imm got %0d want 3", pc_imm); end
      checks++; if (alu_op !== 2'b11) begin failures++; $display("FAIL jmp_alu_op got %0d want 3", alu_op); end
      step();
      checks++; if (rom_addr !== 8'd5) begin failures++; $display("FAIL jmp_target got %0d want 5", rom_addr); end
      // JMP 0 self-loop at address 5
      for (int k = 0; k < 3; k++) begin
         step();
         step();
         checks++; if ({pc_en, pc_imm} !== 4'b1000) begin failures++; $display("FAIL jmp0_strobe iter %0d got %b want 1000", k, {pc_en, pc_imm}); end
         step();
         checks++; if (rom_addr !== 8'd5) begin failures++; $display("FAIL jmp0_addr iter %0d got %0d want 5", k, rom_addr); end
      end
   endtask

   task automatic test_jz();
      clear_rom();
      rom[0] = 8'hA2;
      rom[2] = 8'hA2;
      zero_flag = 1'b0;
      do_reset();
      step();
      zero_flag = 1'b1;
      step();
      checks++; if (pc_imm !== 3'd2) begin failures++; $display("FAIL jz_taken got %0d want 2", pc_imm); end
      step();
      checks++; if (pc_count !== 8'd2) begin failures++; $display("FAIL jz_taken_count got %0d want 2", pc_count); end
      zero_flag = 1'b1;
      step();
      zero_flag = 1'b0;
      step();
      checks++; if (pc_imm !== 3'd1) begin failures++; $display("FAIL jz_not_taken got %0d want 1", pc_imm); end
      checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL jz_pc_en got %b want 1", pc_en); end
      step();
      checks++; if (pc_count !== 8'd3) begin failures++; $display("FAIL jz_not_taken_count got %0d want 3", pc_count); end
      zero_flag = 1'b0;
   endtask

   task automatic test_halt();
      int bad;
      clear_rom();
      rom[0] = 8'hE0;
      do_reset();
      step();
      step();
      checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL hlt_exec_pc_en got %b want 0", pc_en); end
      checks++; if (ir !== 8'hE0) begin failures++; $display("FAIL hlt_ir got %0h want e0", ir); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hlt_early got %b want 0", halted); end
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (halted !== 1'b1 || {reg_we, out_we, pc_en} !== 3'b000 || pc_count !== 8'd0) bad++;
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL hlt_hold bad_cycles got %0d want 0", bad); end
      reset = 1'b1;
      step();
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL hlt_reset_halted got %b want 0", halted); end
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL hlt_reset_ir got %0h want 0", ir); end
      reset = 1'b0;
      step();
      step();
      checks++; if (ir !== 8'hE0) begin failures++; $display("FAIL hlt_refetch_ir got %0h want e0", ir); end
   endtask

   task automatic test_reset_mid_exec();
      clear_rom();
      rom[0] = 8'hC0;
      do_reset();
      step();
      step();
      checks++; if (out_we !== 1'b1) begin failures++; $display("FAIL out_we got %b want 1", out_we); end
      checks++; if (reg_we !== 1'b0) begin failures++; $display("FAIL out_reg_we got %b want 0", reg_we); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if ({reg_we, out_we, pc_en} !== 3'b000) begin failures++; $display("FAIL midrst_strobes got %b want 000", {reg_we, out_we, pc_en}); end
      checks++; if (ir !== 8'h00) begin failures++; $display("FAIL midrst_ir got %0h want 0", ir); end
      checks++; if (pc_count !== 8'd0) begin failures++; $display("FAIL midrst_count got %0d want 0", pc_count); end
      step();
      checks++; if (out_we !== 1'b0) begin failures++; $display("FAIL midrst_load_out_we got %b want 0", out_we); end
      step();
      checks++; if (out_we !== 1'b1) begin failures++; $display("FAIL midrst_reexec_out_we got %b want 1", out_we); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      zero_flag = 1'b0;
      test_reset();
      test_sequential();
      test_jz();
      test_halt();
      test_reset_mid_exec();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
